// File: rtl/data_mem_reader.sv
// data_mem_reader
// Walks a contiguous range of data-RAM addresses after a start pulse and
// streams each word out over a valid/ready handshake. Each word takes a
// FETCH cycle (address presented), a LATCH cycle (RAM output captured) and
// at least one SEND cycle (offered until accepted). The RAM is never written.
module data_mem_reader #(
  parameter int WIDTH      = 12,
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   count_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [WIDTH-1:0]      mem_dataIn_i,
  output logic [WIDTH-1:0]      tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND,
    DONE
  } state_e;

  // A count larger than the RAM is clamped so no word is sent twice.
  localparam logic [ADDR_WIDTH:0]   DepthCount = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   OneCount   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] LastAddr   = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [WIDTH-1:0]      txData_q, txData_d;

  // State, address, word counter and offered word registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      txData_q    <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      txData_q    <= txData_d;
    end
  end

  // Next-state logic: sequence each word through FETCH, LATCH and SEND.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    txData_d    = txData_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d      = base_addr_i;
          remaining_d = (count_i > DepthCount) ? DepthCount : count_i;
          state_d     = (count_i == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        state_d = LATCH;
      end
      LATCH: begin
        txData_d = mem_dataIn_i;
        state_d  = SEND;
      end
      SEND: begin
        if (tx_ready_i) begin
          remaining_d = remaining_q - OneCount;
          if (remaining_q == OneCount) begin
            state_d = DONE;
          end else begin
            addr_d  = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The address register drives the RAM directly, so it stays stable
  // through LATCH and SEND and only advances after a transfer.
  assign mem_addr_o = addr_q;
  assign tx_data_o  = txData_q;
  assign tx_valid_o = (state_q == SEND);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);

endmodule

// File: tb/tb_data_mem_reader.sv
// Directed testbench for data_mem_reader with a behavioural one-cycle
// latency RAM model.
module tb_data_mem_reader;

  localparam int WIDTH = 12;
  localparam int DEPTH = 4096;
  localparam int AW    = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             txReady = 1'b0;
  logic [AW-1:0]    baseAddr = '0;
  logic [AW:0]      count = '0;
  logic [AW-1:0]    memAddr;
  logic [WIDTH-1:0] memData;
  logic [WIDTH-1:0] txData;
  logic             txValid;
  logic             busy;
  logic             done;

  logic [WIDTH-1:0] ram [DEPTH];

  int testsRun = 0;
  int testsFailed = 0;

  logic [WIDTH-1:0] xferData[$];
  int               xferAddr[$];
  int               xferCycle[$];
  int               doneCycles[$];
  bit               validSeen;
  bit               holdBroken;
  bit               timedOut;
  int               busyLowCycle;

  data_mem_reader #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
    .base_addr_i(baseAddr),
    .count_i(count),
    .mem_addr_o(memAddr),
    .mem_dataIn_i(memData),
    .tx_data_o(txData),
    .tx_valid_o(txValid),
    .tx_ready_i(txReady),
    .busy_o(busy),
    .done_o(done)
  );

  always #5 clk = ~clk;

  // Registered-address RAM: output is the word addressed one cycle earlier.
  always_ff @(posedge clk) memData <= ram[memAddr];

  // Runs one dump starting with start high in cycle 0. Inputs are driven and
  // outputs observed on the falling edge. Records transfers, done pulses and
  // the cycle busy falls; optionally stalls one word and pokes start mid-dump.
  task automatic runDump(input logic [AW-1:0] base, input logic [AW:0] cnt,
                         input int stallWord, input int stallLen,
                         input bit pokeStart, input int budget);
    int cyc = 0;
    int stallLeft = stallLen;
    bit holding = 1'b0;
    logic [WIDTH-1:0] heldData = '0;
    xferData.delete();
    xferAddr.delete();
    xferCycle.delete();
    doneCycles.delete();
    validSeen = 1'b0;
    holdBroken = 1'b0;
    timedOut = 1'b0;
    busyLowCycle = -1;
    @(negedge clk);
    start = 1'b1;
    baseAddr = base;
    count = cnt;
    txReady = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      baseAddr = base;
      count = cnt;
      if (pokeStart && (cyc <= 3 || done)) begin
        start = 1'b1;
        baseAddr = base + 12'd1000;
        count = 13'd2;
      end
      if (cyc > budget) begin
        timedOut = 1'b1;
        break;
      end
      if (txValid && stallLeft > 0 && xferData.size() == stallWord) begin
        txReady = 1'b0;
        stallLeft--;
      end else begin
        txReady = 1'b1;
      end
      if (txValid) begin
        validSeen = 1'b1;
        if (holding && txData !== heldData) holdBroken = 1'b1;
        holding = 1'b1;
        heldData = txData;
      end else if (holding) begin
        holdBroken = 1'b1;
      end
      if (txValid && txReady) begin
        xferData.push_back(txData);
        xferAddr.push_back(int'(memAddr));
        xferCycle.push_back(cyc);
        holding = 1'b0;
      end
      if (done) doneCycles.push_back(cyc);
      if (!busy) begin
        busyLowCycle = cyc;
        break;
      end
    end
    start = 1'b0;
    txReady = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    testsRun++;
    if (busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
    testsRun++;
    if (txValid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_tx_valid: got %0b expected 0", txValid); end
    testsRun++;
    if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %0b expected 0", done); end
    testsRun++;
    if (txData !== 12'h000) begin testsFailed++; $display("[TB] FAIL reset_tx_data: got %0h expected 0", txData); end
    testsRun++;
    if (memAddr !== 12'h000) begin testsFailed++; $display("[TB] FAIL reset_mem_addr: got %0h expected 0", memAddr); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] expData [4] = '{12'h00A, 12'h0B1, 12'hFFF, 12'h123};
    int expCycle [4] = '{3, 6, 9, 12};
    runDump(12'd0, 13'd4, -1, 0, 1'b0, 100);
    testsRun++;
    if (timedOut !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_timeout: got %0b expected 0", timedOut); end
    testsRun++;
    if (xferData.size() != 4) begin testsFailed++; $display("[TB] FAIL basic_count: got %0d expected 4", xferData.size()); end
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (i >= xferData.size()) begin
        testsFailed++; $display("[TB] FAIL basic_word%0d: got nothing expected %0h", i, expData[i]);
      end else if (xferData[i] !== expData[i] || xferCycle[i] != expCycle[i]) begin
        testsFailed++;
        $display("[TB] FAIL basic_word%0d: got %0h in cycle %0d expected %0h in cycle %0d",
                 i, xferData[i], xferCycle[i], expData[i], expCycle[i]);
      end
    end
    testsRun++;
    if (doneCycles.size() != 1 || doneCycles[0] != 13) begin
      testsFailed++; $display("[TB] FAIL basic_done: got %0d pulses first cycle %0d expected 1 pulse in cycle 13",
                              doneCycles.size(), (doneCycles.size() > 0) ? doneCycles[0] : -1);
    end
    testsRun++;
    if (busyLowCycle != 14) begin testsFailed++; $display("[TB] FAIL basic_busy_fall: got %0d expected 14", busyLowCycle); end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] expData [4] = '{12'h00A, 12'h0B1, 12'hFFF, 12'h123};
    int expCycle [4] = '{3, 11, 14, 17};
    runDump(12'd0, 13'd4, 1, 5, 1'b0, 100);
    testsRun++;
    if (xferData.size() != 4) begin testsFailed++; $display("[TB] FAIL bp_count: got %0d expected 4", xferData.size()); end
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (i >= xferData.size()) begin
        testsFailed++; $display("[TB] FAIL bp_word%0d: got nothing expected %0h", i, expData[i]);
      end else if (xferData[i] !== expData[i] || xferCycle[i] != expCycle[i]) begin
        testsFailed++;
        $display("[TB] FAIL bp_word%0d: got %0h in cycle %0d expected %0h in cycle %0d",
                 i, xferData[i], xferCycle[i], expData[i], expCycle[i]);
      end
    end
    testsRun++;
    if (holdBroken !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_hold: got broken=%0b expected 0", holdBroken); end
    testsRun++;
    if (doneCycles.size() != 1 || doneCycles[0] != 18) begin
      testsFailed++; $display("[TB] FAIL bp_done: got %0d pulses first cycle %0d expected 1 pulse in cycle 18",
                              doneCycles.size(), (doneCycles.size() > 0) ? doneCycles[0] : -1);
    end
  endtask

  task automatic test_wrap();
    int expAddr [4] = '{4094, 4095, 0, 1};
    runDump(12'd4094, 13'd4, -1, 0, 1'b0, 100);
    testsRun++;
    if (xferData.size() != 4) begin testsFailed++; $display("[TB] FAIL wrap_count: got %0d expected 4", xferData.size()); end
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (i >= xferData.size()) begin
        testsFailed++; $display("[TB] FAIL wrap_word%0d: got nothing expected addr %0d", i, expAddr[i]);
      end else if (xferAddr[i] != expAddr[i] || xferData[i] !== ram[expAddr[i]]) begin
        testsFailed++;
        $display("[TB] FAIL wrap_word%0d: got addr %0d data %0h expected addr %0d data %0h",
                 i, xferAddr[i], xferData[i], expAddr[i], ram[expAddr[i]]);
      end
    end
  endtask

  task automatic test_count_zero();
    runDump(12'd55, 13'd0, -1, 0, 1'b0, 20);
    testsRun++;
    if (doneCycles.size() != 1 || doneCycles[0] != 1) begin
      testsFailed++; $display("[TB] FAIL zero_done: got %0d pulses first cycle %0d expected 1 pulse in cycle 1",
                              doneCycles.size(), (doneCycles.size() > 0) ? doneCycles[0] : -1);
    end
    testsRun++;
    if (validSeen !== 1'b0) begin testsFailed++; $display("[TB] FAIL zero_valid: got %0b expected 0", validSeen); end
    testsRun++;
    if (busyLowCycle != 2) begin testsFailed++; $display("[TB] FAIL zero_busy_fall: got %0d expected 2", busyLowCycle); end
  endtask

  task automatic test_count_saturate();
    int badCount = 0;
    runDump(12'd10, 13'd5000, -1, 0, 1'b0, 13000);
    testsRun++;
    if (xferData.size() != DEPTH) begin testsFailed++; $display("[TB] FAIL sat_count: got %0d expected %0d", xferData.size(), DEPTH); end
    for (int i = 0; i < xferData.size(); i++) begin
      int a = (10 + i) % DEPTH;
      if (xferAddr[i] != a || xferData[i] !== ram[a]) badCount++;
    end
    testsRun++;
    if (badCount != 0) begin testsFailed++; $display("[TB] FAIL sat_words: got %0d bad words expected 0", badCount); end
    testsRun++;
    if (doneCycles.size() != 1 || doneCycles[0] != 3 * DEPTH + 1) begin
      testsFailed++; $display("[TB] FAIL sat_done: got %0d pulses first cycle %0d expected 1 pulse in cycle %0d",
                              doneCycles.size(), (doneCycles.size() > 0) ? doneCycles[0] : -1, 3 * DEPTH + 1);
    end
  endtask

  task automatic test_reset_mid_send();
    int sent = 0;
    bit reached = 1'b0;
    bit sawDone = 1'b0;
    @(negedge clk);
    start = 1'b1; baseAddr = 12'd0; count = 13'd4; txReady = 1'b1;
    for (int k = 0; k < 40 && !reached; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) sawDone = 1'b1;
      if (txValid && sent == 2) reached = 1'b1;
      else if (txValid && txReady) sent++;
    end
    rst = 1'b1;
    #1;
    testsRun++;
    if (reached !== 1'b1) begin testsFailed++; $display("[TB] FAIL rst_reach_third: got %0b expected 1", reached); end
    testsRun++;
    if ({busy, txValid, done} !== 3'b000) begin
      testsFailed++; $display("[TB] FAIL rst_flags: got busy/valid/done %03b expected 000", {busy, txValid, done});
    end
    testsRun++;
    if (txData !== 12'h000 || memAddr !== 12'h000) begin
      testsFailed++; $display("[TB] FAIL rst_values: got data %0h addr %0h expected 0 0", txData, memAddr);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) sawDone = 1'b1;
    end
    testsRun++;
    if (sawDone !== 1'b0) begin testsFailed++; $display("[TB] FAIL rst_no_done: got activity=%0b expected 0", sawDone); end
    runDump(12'd0, 13'd1, -1, 0, 1'b0, 20);
    testsRun++;
    if (xferData.size() != 1 || xferCycle[0] != 3 || xferData[0] !== ram[0]) begin
      testsFailed++; $display("[TB] FAIL rst_restart: got %0d words first %0h in cycle %0d expected 1 word %0h in cycle 3",
                              xferData.size(), (xferData.size() > 0) ? xferData[0] : 12'h000,
                              (xferCycle.size() > 0) ? xferCycle[0] : -1, ram[0]);
    end
  endtask

  task automatic test_start_while_busy();
    logic [WIDTH-1:0] expData [4] = '{12'h00A, 12'h0B1, 12'hFFF, 12'h123};
    runDump(12'd0, 13'd4, -1, 0, 1'b1, 100);
    testsRun++;
    if (xferData.size() != 4) begin testsFailed++; $display("[TB] FAIL busy_start_count: got %0d expected 4", xferData.size()); end
    for (int i = 0; i < 4; i++) begin
      testsRun++;
      if (i >= xferData.size()) begin
        testsFailed++; $display("[TB] FAIL busy_start_word%0d: got nothing expected %0h", i, expData[i]);
      end else if (xferData[i] !== expData[i] || xferAddr[i] != i || xferCycle[i] != 3 + 3 * i) begin
        testsFailed++;
        $display("[TB] FAIL busy_start_word%0d: got %0h addr %0d cycle %0d expected %0h addr %0d cycle %0d",
                 i, xferData[i], xferAddr[i], xferCycle[i], expData[i], i, 3 + 3 * i);
      end
    end
    testsRun++;
    if (doneCycles.size() != 1 || doneCycles[0] != 13 || busyLowCycle != 14) begin
      testsFailed++; $display("[TB] FAIL busy_start_end: got %0d pulses busy fall %0d expected 1 pulse busy fall 14",
                              doneCycles.size(), busyLowCycle);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = WIDTH'((i * 37 + 5) ^ (i >> 3));
    ram[0] = 12'h00A;
    ram[1] = 12'h0B1;
    ram[2] = 12'hFFF;
    ram[3] = 12'h123;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_count_zero();
    test_count_saturate();
    test_reset_mid_send();
    test_start_while_busy();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/data_mem_reader.md
# data_mem_reader

Sequential reader for the per-core data memory. On a `start` pulse it walks a contiguous range of data-RAM addresses and streams each word out over a valid/ready handshake, typically to the UART transmitter, so results can be shipped off-chip after `processDone`. It sits beside the data RAM and owns the RAM read address while `busy` is high. The top level muxes the RAM address to it and holds the RAM's `wrEn` low. It accounts for the RAM's registered-address, one-cycle read latency.

## Interface
- `WIDTH`, 12, data word width; matches the data RAM.
- `DEPTH`, 4096, number of RAM words.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, RAM address width.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first address to read; sampled with `start`.
- `count`  in  ADDR_WIDTH+1  number of words; sampled with `start`.
- `mem_addr`  out  ADDR_WIDTH  address to the data RAM; registered.
- `mem_dataIn`  in  WIDTH  RAM `dataOut`, which is the word at the address presented one cycle earlier.
- `tx_data`  out  WIDTH  word being offered.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  consumer accepts; a transfer occurs when `tx_valid && tx_ready` at a rising edge.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a dump.

## Operation
- FSM states: IDLE, FETCH, LATCH, SEND, DONE.
- **IDLE**
  - On `start`, load `addr <= base_addr` and `remaining <= min(count, DEPTH)`.
  - If `count == 0`, go to DONE; otherwise go to FETCH.
- **FETCH**
  - `mem_addr` = `addr`.
  - The RAM registers this address at the end of the cycle.
  - Next state: LATCH.
- **LATCH**
  - `mem_dataIn` holds `mem[addr]`.
  - `tx_data <= mem_dataIn`; go to SEND.
- **SEND**
  - `tx_valid` = 1; `tx_data` and `mem_addr` are held stable.
  - On a transfer, decrement `remaining`.
  - If the pre-decrement value of `remaining` was 1, go to DONE.
  - Otherwise `addr <= addr + 1` (mod DEPTH) and go to FETCH.
- **DONE**
  - `done` = 1 for exactly one cycle, then go to IDLE.
- `start` is ignored outside IDLE.
- `tx_ready` is ignored outside SEND.
- Address wrap-around: after address DEPTH-1 the next address is 0.
- `count > DEPTH` saturates to DEPTH, so no word is sent twice in one dump.
- The block never writes the RAM.

## Timing
- Reset values (asynchronous, immediate):
  - state = IDLE
  - `addr`, `mem_addr`, `remaining`, `tx_data` = 0
  - `tx_valid`, `busy`, `done` = 0
- Cycle numbering: `start` is high in cycle 0 and sampled at the end of cycle 0.
- Cycle sequence for a dump:
  - Cycle 1: FETCH, `busy` = 1.
  - Cycle 2: LATCH.
  - Cycle 3: SEND, `tx_valid` first high.
- With `tx_ready` held high, word i transfers in cycle 3+3i.
- For N words with no backpressure, `done` is high in cycle 3N+1 and `busy` falls in cycle 3N+2.
- `count == 0`: `done` in cycle 1, `busy` high only in cycle 1, `tx_valid` never asserted.
- Backpressure: each cycle of `tx_ready` low in SEND adds one cycle. `tx_valid` stays high and `tx_data` is unchanged until the transfer.
- `tx_valid` drops in the cycle after a transfer; there is no back-to-back valid between words.
- Reset mid-operation aborts the dump: no `done` pulse, outputs return to reset values, and the next `start` behaves normally.
- `start` high in the DONE cycle is ignored. A `start` in the first IDLE cycle after DONE is accepted.

## Test plan
- **Basic dump.** RAM[0..3] = 12'h00A, 12'h0B1, 12'hFFF, 12'h123; `tx_ready`=1; `start`, `base_addr`=0, `count`=4.
  - Required: transfers in cycles 3, 6, 9, 12 carrying those values in order.
  - Required: `done` in cycle 13 only.
- **Backpressure.** Same setup; hold `tx_ready`=0 for 5 cycles during the second SEND.
  - Required: `tx_data`=12'h0B1 stable with `tx_valid`=1 throughout, no duplicate or dropped word.
  - Required: `done` in cycle 18.
- **Wrap-around.** `base_addr`=4094, `count`=4.
  - Required: `mem_addr` sequence 4094, 4095, 0, 1; data matches RAM at those addresses.
- **Count edge cases.**
  - `count`=0: `done` in cycle 1, `tx_valid` never high.
  - `count`=5000: exactly 4096 transfers covering every address once, then `done`.
- **Reset mid-SEND.** Assert `rst` while `tx_valid`=1 during the third word.
  - Required: all outputs 0 immediately and no `done` pulse.
  - Required: a following `start`, `base_addr`=0, `count`=1 delivers RAM[0] in cycle 3.
- **Start while busy.** Pulse `start` with a different `base_addr` during FETCH, LATCH and SEND.
  - Required: it is ignored and the original sequence completes unchanged.
